riscv_core_me_stage: RTL and testbench

- Memory-stage consumer of the EX→ME pipeline-register write interface (the `r_me_*_D` / `r_me_*_WE` pairs driven by the EX output unit).
- Holds the ME pipeline registers and runs the data-memory transaction over a valid/ready request and response bus.
- Resolves branches, produces the writeback payload for the WB registers, and stalls upstream while a memory access is outstanding.

---
 rtl/riscv_core_me_stage.sv | 207 ++++++++++++++++++++
 tb/tb_riscv_core_me_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_me_stage.sv
// Memory stage: holds the ME pipeline registers, runs the data-memory request/response
// handshake, resolves branches and presents the writeback payload.
module riscv_core_me_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] r_me_pc_D,
  input  logic [31:0] r_me_alu_D,
  input  logic [31:0] r_me_bradd_D,
  input  logic [31:0] r_me_wtdat_D,
  input  logic [4:0]  r_me_rd_D,
  input  logic [3:0]  r_me_memop_D,
  input  logic [2:0]  r_me_branchop_D,
  input  logic [1:0]  r_me_rfwt_sel_D,
  input  logic        r_me_regwrite_D,
  input  logic        r_me_zero_D,
  input  logic        r_me_pc_WE,
  input  logic        r_me_alu_WE,
  input  logic        r_me_bradd_WE,
  input  logic        r_me_wtdat_WE,
  input  logic        r_me_rd_WE,
  input  logic        r_me_memop_WE,
  input  logic        r_me_branchop_WE,
  input  logic        r_me_rfwt_sel_WE,
  input  logic        r_me_regwrite_WE,
  input  logic        r_me_zero_WE,
  output logic        me_stall_o,
  output logic        dm_req_valid_o,
  output logic        dm_req_we_o,
  output logic [31:0] dm_req_addr_o,
  output logic [3:0]  dm_req_be_o,
  output logic [31:0] dm_req_wdata_o,
  input  logic        dm_req_ready_i,
  input  logic        dm_rsp_valid_i,
  input  logic [31:0] dm_rsp_rdata_i,
  output logic        br_taken_o,
  output logic [31:0] br_target_o,
  output logic        misaligned_o,
  output logic [4:0]  r_wb_rd_D,
  output logic [31:0] r_wb_data_D,
  output logic        r_wb_regwrite_D,
  output logic        r_wb_WE
);

  localparam logic [3:0] MOP_LB  = 4'd1;
  localparam logic [3:0] MOP_LH  = 4'd2;
  localparam logic [3:0] MOP_LW  = 4'd3;
  localparam logic [3:0] MOP_LBU = 4'd4;
  localparam logic [3:0] MOP_LHU = 4'd5;
  localparam logic [3:0] MOP_SB  = 4'd8;
  localparam logic [3:0] MOP_SH  = 4'd9;
  localparam logic [3:0] MOP_SW  = 4'd10;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state_q;
  logic [31:0] pc_q, alu_q, bradd_q, wtdat_q;
  logic [4:0]  rd_q;
  logic [3:0]  memop_q;
  logic [2:0]  branchop_q;
  logic [1:0]  rfwt_sel_q;
  logic        regwrite_q, zero_q, valid_q;

  function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] lane,
                                               input logic [31:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        res;
    b = rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      MOP_LB:  res = 32'(b);
      MOP_LH:  res = 32'(h);
      MOP_LBU: res = {24'b0, b};
      MOP_LHU: res = {16'b0, h};
      default: res = rdata;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] store_be(input logic [3:0] op, input logic [1:0] lane);
    logic [3:0] res;
    case (op)
      MOP_SB:  res = 4'b0001 << lane;
      MOP_SH:  res = lane[1] ? 4'b1100 : 4'b0011;
      default: res = 4'b1111;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [3:0] op, input logic [31:0] wt);
    logic [31:0] res;
    case (op)
      MOP_SB:  res = {4{wt[7:0]}};
      MOP_SH:  res = {2{wt[15:0]}};
      default: res = wt;
    endcase
    return res;
  endfunction

  function automatic logic branch_cond(input logic [2:0] bop, input logic zero, input logic alu0);
    logic res;
    case (bop)
      3'd1:    res = zero;
      3'd2:    res = ~zero;
      3'd3:    res = alu0;
      3'd4:    res = ~alu0;
      3'd5:    res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  logic        is_load, is_store, is_mem, misal, aligned_mem;
  logic        retire, stall, req_valid, live, wb_fire, taken;
  logic [1:0]  lane;
  logic [31:0] wb_data;
  logic        unused_we_ok;

  // Only the pc enable carries meaning; EX drives all enables identically.
  assign unused_we_ok = &{r_me_alu_WE, r_me_bradd_WE, r_me_wtdat_WE, r_me_rd_WE, r_me_memop_WE,
                          r_me_branchop_WE, r_me_rfwt_sel_WE, r_me_regwrite_WE, r_me_zero_WE};

  assign lane     = alu_q[1:0];
  assign is_load  = (memop_q == MOP_LB) || (memop_q == MOP_LH) || (memop_q == MOP_LW) ||
                    (memop_q == MOP_LBU) || (memop_q == MOP_LHU);
  assign is_store = (memop_q == MOP_SB) || (memop_q == MOP_SH) || (memop_q == MOP_SW);
  assign is_mem   = is_load | is_store;
  assign misal    = (((memop_q == MOP_LH) || (memop_q == MOP_LHU) || (memop_q == MOP_SH)) && alu_q[0]) ||
                    (((memop_q == MOP_LW) || (memop_q == MOP_SW)) && (alu_q[1:0] != 2'b00));
  assign aligned_mem = is_mem & ~misal;

  always_comb begin
    retire = 1'b0;
    if (valid_q) begin
      if (!aligned_mem)            retire = 1'b1;
      else if (state_q == S_IDLE)  retire = is_store & dm_req_ready_i;
      else                         retire = dm_rsp_valid_i;
    end
  end

  assign stall     = valid_q & aligned_mem & ~retire;
  assign req_valid = valid_q & aligned_mem & (state_q == S_IDLE);

  always_comb begin
    case (rfwt_sel_q)
      2'd1:    wb_data = load_extract(memop_q, lane, dm_rsp_rdata_i);
      2'd2:    wb_data = pc_q + 32'd4;
      default: wb_data = alu_q;
    endcase
  end

  // Outputs are forced to zero while reset is asserted.
  assign live    = ~RST;
  assign wb_fire = live & retire;
  assign taken   = wb_fire & branch_cond(branchop_q, zero_q, alu_q[0]);

  assign me_stall_o      = live & stall;
  assign dm_req_valid_o  = live & req_valid;
  assign dm_req_we_o     = live & req_valid & is_store;
  assign dm_req_addr_o   = (live & req_valid) ? alu_q : 32'd0;
  assign dm_req_be_o     = (live & req_valid) ? (is_store ? store_be(memop_q, lane) : 4'b1111) : 4'b0000;
  assign dm_req_wdata_o  = (live & req_valid & is_store) ? store_wdata(memop_q, wtdat_q) : 32'd0;
  assign br_taken_o      = taken;
  assign br_target_o     = taken ? bradd_q : 32'd0;
  assign misaligned_o    = live & valid_q & is_mem & misal;
  assign r_wb_WE         = wb_fire;
  assign r_wb_rd_D       = live ? rd_q : 5'd0;
  assign r_wb_regwrite_D = live & regwrite_q & ~(is_mem & misal);
  assign r_wb_data_D     = live ? wb_data : 32'd0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      valid_q    <= 1'b0;
      pc_q       <= '0;
      alu_q      <= '0;
      bradd_q    <= '0;
      wtdat_q    <= '0;
      rd_q       <= '0;
      memop_q    <= '0;
      branchop_q <= '0;
      rfwt_sel_q <= '0;
      regwrite_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      if (!stall) begin
        valid_q    <= r_me_pc_WE;
        pc_q       <= r_me_pc_D;
        alu_q      <= r_me_alu_D;
        bradd_q    <= r_me_bradd_D;
        wtdat_q    <= r_me_wtdat_D;
        rd_q       <= r_me_rd_D;
        memop_q    <= r_me_memop_D;
        branchop_q <= r_me_branchop_D;
        rfwt_sel_q <= r_me_rfwt_sel_D;
        regwrite_q <= r_me_regwrite_D;
        zero_q     <= r_me_zero_D;
      end
      case (state_q)
        S_IDLE:  if (req_valid && is_load && dm_req_ready_i) state_q <= S_WAIT;
        S_WAIT:  if (dm_rsp_valid_i) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_core_me_stage.sv
// Scoreboard bench for riscv_core_me_stage: stimulus pushes expected WB writes, memory
// requests and branch redirects; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_riscv_core_me_stage;
  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] pc_d, alu_d, bradd_d, wtdat_d;
  logic [4:0]  rd_d;
  logic [3:0]  memop_d;
  logic [2:0]  bop_d;
  logic [1:0]  sel_d;
  logic        rw_d, zero_d, we;
  logic        me_stall_o, dm_req_valid_o, dm_req_we_o;
  logic [31:0] dm_req_addr_o, dm_req_wdata_o;
  logic [3:0]  dm_req_be_o;
  logic        dm_req_ready_i, dm_rsp_valid_i;
  logic [31:0] dm_rsp_rdata_i;
  logic        br_taken_o, misaligned_o, r_wb_regwrite_D, r_wb_WE;
  logic [31:0] br_target_o, r_wb_data_D;
  logic [4:0]  r_wb_rd_D;

  always #5 CLK = ~CLK;

  riscv_core_me_stage dut (
    .CLK(CLK), .RST(RST),
    .r_me_pc_D(pc_d), .r_me_alu_D(alu_d), .r_me_bradd_D(bradd_d), .r_me_wtdat_D(wtdat_d),
    .r_me_rd_D(rd_d), .r_me_memop_D(memop_d), .r_me_branchop_D(bop_d), .r_me_rfwt_sel_D(sel_d),
    .r_me_regwrite_D(rw_d), .r_me_zero_D(zero_d),
    .r_me_pc_WE(we), .r_me_alu_WE(we), .r_me_bradd_WE(we), .r_me_wtdat_WE(we), .r_me_rd_WE(we),
    .r_me_memop_WE(we), .r_me_branchop_WE(we), .r_me_rfwt_sel_WE(we), .r_me_regwrite_WE(we),
    .r_me_zero_WE(we),
    .me_stall_o(me_stall_o), .dm_req_valid_o(dm_req_valid_o), .dm_req_we_o(dm_req_we_o),
    .dm_req_addr_o(dm_req_addr_o), .dm_req_be_o(dm_req_be_o), .dm_req_wdata_o(dm_req_wdata_o),
    .dm_req_ready_i(dm_req_ready_i), .dm_rsp_valid_i(dm_rsp_valid_i), .dm_rsp_rdata_i(dm_rsp_rdata_i),
    .br_taken_o(br_taken_o), .br_target_o(br_target_o), .misaligned_o(misaligned_o),
    .r_wb_rd_D(r_wb_rd_D), .r_wb_data_D(r_wb_data_D), .r_wb_regwrite_D(r_wb_regwrite_D),
    .r_wb_WE(r_wb_WE)
  );

  typedef struct { logic [4:0] rd; logic [31:0] data; logic rw; } wb_t;
  typedef struct { logic wr; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; bit chk_wd; } req_t;

  wb_t         wb_q[$];
  req_t        req_q[$];
  logic [31:0] br_q[$];
  int total = 0, bad = 0, mis_seen = 0, exp_mis = 0;

  logic nz;
  assign nz = |{me_stall_o, dm_req_valid_o, dm_req_we_o, dm_req_addr_o, dm_req_be_o, dm_req_wdata_o,
                br_taken_o, br_target_o, misaligned_o, r_wb_rd_D, r_wb_data_D, r_wb_regwrite_D, r_wb_WE};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    wb_t         ew;
    req_t        er;
    logic [31:0] eb;
    if (r_wb_WE === 1'b1) begin
      if (wb_q.size() == 0) chk("wb_unexpected", 32'(r_wb_WE), 32'd0);
      else begin
        ew = wb_q.pop_front();
        chk("wb_rd", 32'(r_wb_rd_D), 32'(ew.rd));
        chk("wb_data", r_wb_data_D, ew.data);
        chk("wb_regwrite", 32'(r_wb_regwrite_D), 32'(ew.rw));
      end
    end
    if (dm_req_valid_o === 1'b1 && dm_req_ready_i === 1'b1) begin
      if (req_q.size() == 0) chk("req_unexpected", 32'(dm_req_valid_o), 32'd0);
      else begin
        er = req_q.pop_front();
        chk("req_we", 32'(dm_req_we_o), 32'(er.wr));
        chk("req_addr", dm_req_addr_o, er.addr);
        chk("req_be", 32'(dm_req_be_o), 32'(er.be));
        if (er.chk_wd) chk("req_wdata", dm_req_wdata_o, er.wdata);
      end
    end
    if (br_taken_o === 1'b1) begin
      if (br_q.size() == 0) chk("br_unexpected", 32'(br_taken_o), 32'd0);
      else begin
        eb = br_q.pop_front();
        chk("br_target", br_target_o, eb);
      end
    end
    if (misaligned_o === 1'b1) mis_seen++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] bradd,
                      input logic [31:0] wtdat, input logic [4:0] rd, input logic [3:0] mop,
                      input logic [2:0] bop, input logic [1:0] sel, input logic rw, input logic zero);
    pc_d = pc; alu_d = alu; bradd_d = bradd; wtdat_d = wtdat; rd_d = rd;
    memop_d = mop; bop_d = bop; sel_d = sel; rw_d = rw; zero_d = zero; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic mem_run(input int rdy_dly, input bit ld, input int rsp_dly, input logic [31:0] rdata,
                         input logic [31:0] eaddr, input logic [3:0] ebe, input bit early_rsp);
    for (int i = 0; i < rdy_dly; i++) begin
      dm_rsp_valid_i = early_rsp;
      #1;
      chk("stall_req_wait", 32'(me_stall_o), 32'd1);
      chk("req_valid_hold", 32'(dm_req_valid_o), 32'd1);
      chk("req_addr_hold", dm_req_addr_o, eaddr);
      chk("req_be_hold", 32'(dm_req_be_o), 32'(ebe));
      chk("wb_we_idle", 32'(r_wb_WE), 32'd0);
      tick();
    end
    dm_rsp_valid_i = 1'b0;
    dm_req_ready_i = 1'b1;
    tick();
    dm_req_ready_i = 1'b0;
    if (ld) begin
      for (int i = 0; i < rsp_dly; i++) begin
        chk("stall_rsp_wait", 32'(me_stall_o), 32'd1);
        chk("req_valid_in_wait", 32'(dm_req_valid_o), 32'd0);
        tick();
      end
      dm_rsp_rdata_i = rdata;
      dm_rsp_valid_i = 1'b1;
      tick();
      dm_rsp_valid_i = 1'b0;
      dm_rsp_rdata_i = 32'd0;
    end
    chk("stall_after_retire", 32'(me_stall_o), 32'd0);
  endtask

  initial begin
    RST = 1'b1; we = 1'b0;
    pc_d = '0; alu_d = '0; bradd_d = '0; wtdat_d = '0; rd_d = '0;
    memop_d = '0; bop_d = '0; sel_d = '0; rw_d = 1'b0; zero_d = 1'b0;
    dm_req_ready_i = 1'b0; dm_rsp_valid_i = 1'b0; dm_rsp_rdata_i = '0;
    tick(); tick();
    chk("outputs_in_reset", 32'(nz), 32'd0);
    RST = 1'b0;
    #1;
    chk("outputs_after_reset", 32'(nz), 32'd0);

    // ALU result writeback
    wb_q.push_back('{rd: 5'd5, data: 32'h0000_1234, rw: 1'b1});
    send(32'h40, 32'h1234, 32'h0, 32'h0, 5'd5, 4'd0, 3'd0, 2'd0, 1'b1, 1'b0);
    chk("alu_no_stall", 32'(me_stall_o), 32'd0);
    chk("alu_wb_we", 32'(r_wb_WE), 32'd1);

    // link value pc+4 wraps; unconditional branch
    wb_q.push_back('{rd: 5'd1, data: 32'h0, rw: 1'b1});
    br_q.push_back(32'h200);
    send(32'hFFFF_FFFC, 32'h0, 32'h200, 32'h0, 5'd1, 4'd0, 3'd5, 2'd2, 1'b1, 1'b0);
    tick();

    // LW with delayed ready and delayed response
    req_q.push_back('{wr: 1'b0, addr: 32'h100, be: 4'hF, wdata: 32'h0, chk_wd: 1'b0});
    wb_q.push_back('{rd: 5'd10, data: 32'hDEAD_BEEF, rw: 1'b1});
    send(32'h44, 32'h100, 32'h0, 32'h0, 5'd10, 4'd3, 3'd0, 2'd1, 1'b1, 1'b0);
    mem_run(2, 1'b1, 2, 32'hDEAD_BEEF, 32'h100, 4'hF, 1'b0);

    // LB / LBU on top byte; response seen while IDLE must be ignored
    req_q.push_back('{wr: 1'b0, addr: 32'h103, be: 4'hF, wdata: 32'h0, chk_wd: 1'b0});
    wb_q.push_back('{rd: 5'd11, data: 32'hFFFF_FF80, rw: 1'b1});
    send(32'h48, 32'h103, 32'h0, 32'h0, 5'd11, 4'd1, 3'd0, 2'd1, 1'b1, 1'b0);
    mem_run(1, 1'b1, 0, 32'h80FF_00FF, 32'h103, 4'hF, 1'b1);
    req_q.push_back('{wr: 1'b0, addr: 32'h103, be: 4'hF, wdata: 32'h0, chk_wd: 1'b0});
    wb_q.push_back('{rd: 5'd12, data: 32'h0000_0080, rw: 1'b1});
    send(32'h4C, 32'h103, 32'h0, 32'h0, 5'd12, 4'd4, 3'd0, 2'd1, 1'b1, 1'b0);
    mem_run(0, 1'b1, 0, 32'h80FF_00FF, 32'h103, 4'hF, 1'b0);

    // LH upper half sign-extended, LHU lower half zero-extended
    req_q.push_back('{wr: 1'b0, addr: 32'h102, be: 4'hF, wdata: 32'h0, chk_wd: 1'b0});
    wb_q.push_back('{rd: 5'd13, data: 32'hFFFF_8001, rw: 1'b1});
    send(32'h50, 32'h102, 32'h0, 32'h0, 5'd13, 4'd2, 3'd0, 2'd1, 1'b1, 1'b0);
    mem_run(0, 1'b1, 1, 32'h8001_0000, 32'h102, 4'hF, 1'b0);
    req_q.push_back('{wr: 1'b0, addr: 32'h100, be: 4'hF, wdata: 32'h0, chk_wd: 1'b0});
    wb_q.push_back('{rd: 5'd14, data: 32'h0000_F00D, rw: 1'b1});
    send(32'h54, 32'h100, 32'h0, 32'h0, 5'd14, 4'd5, 3'd0, 2'd1, 1'b1, 1'b0);
    mem_run(0, 1'b1, 0, 32'h1234_F00D, 32'h100, 4'hF, 1'b0);

    // stores: SH upper lanes, SB lane 1, SW
    req_q.push_back('{wr: 1'b1, addr: 32'h102, be: 4'b1100, wdata: 32'hABCD_ABCD, chk_wd: 1'b1});
    wb_q.push_back('{rd: 5'd0, data: 32'h102, rw: 1'b0});
    send(32'h60, 32'h102, 32'h0, 32'h0000_ABCD, 5'd0, 4'd9, 3'd0, 2'd0, 1'b0, 1'b0);
    mem_run(1, 1'b0, 0, 32'h0, 32'h102, 4'b1100, 1'b0);
    req_q.push_back('{wr: 1'b1, addr: 32'h101, be: 4'b0010, wdata: 32'h5A5A_5A5A, chk_wd: 1'b1});
    wb_q.push_back('{rd: 5'd0, data: 32'h101, rw: 1'b0});
    send(32'h64, 32'h101, 32'h0, 32'h1234_565A, 5'd0, 4'd8, 3'd0, 2'd0, 1'b0, 1'b0);
    mem_run(0, 1'b0, 0, 32'h0, 32'h101, 4'b0010, 1'b0);
    req_q.push_back('{wr: 1'b1, addr: 32'h200, be: 4'hF, wdata: 32'hCAFE_F00D, chk_wd: 1'b1});
    wb_q.push_back('{rd: 5'd0, data: 32'h200, rw: 1'b0});
    send(32'h68, 32'h200, 32'h0, 32'hCAFE_F00D, 5'd0, 4'd10, 3'd0, 2'd0, 1'b0, 1'b0);
    mem_run(0, 1'b0, 0, 32'h0, 32'h200, 4'hF, 1'b0);

    // misaligned LW and SH: no request, one-cycle retire, regwrite suppressed
    exp_mis++;
    wb_q.push_back('{rd: 5'd7, data: 32'h0, rw: 1'b0});
    send(32'h6C, 32'h101, 32'h0, 32'h0, 5'd7, 4'd3, 3'd0, 2'd1, 1'b1, 1'b0);
    chk("mis_lw_no_stall", 32'(me_stall_o), 32'd0);
    chk("mis_lw_no_req", 32'(dm_req_valid_o), 32'd0);
    chk("mis_lw_pulse", 32'(misaligned_o), 32'd1);
    exp_mis++;
    wb_q.push_back('{rd: 5'd0, data: 32'h103, rw: 1'b0});
    send(32'h70, 32'h103, 32'h0, 32'h1111, 5'd0, 4'd9, 3'd0, 2'd0, 1'b0, 1'b0);
    chk("mis_sh_no_req", 32'(dm_req_valid_o), 32'd0);
    tick();
    chk("mis_pulse_ends", 32'(misaligned_o), 32'd0);

    // branch conditions
    br_q.push_back(32'h400);
    wb_q.push_back('{rd: 5'd0, data: 32'h5, rw: 1'b0});
    send(32'h74, 32'h5, 32'h400, 32'h0, 5'd0, 4'd0, 3'd1, 2'd0, 1'b0, 1'b1);
    chk("beq_taken", 32'(br_taken_o), 32'd1);
    wb_q.push_back('{rd: 5'd0, data: 32'h8, rw: 1'b0});
    send(32'h78, 32'h8, 32'h440, 32'h0, 5'd0, 4'd0, 3'd2, 2'd0, 1'b0, 1'b1);
    chk("bne_not_taken", 32'(br_taken_o), 32'd0);
    br_q.push_back(32'h480);
    wb_q.push_back('{rd: 5'd0, data: 32'h9, rw: 1'b0});
    send(32'h7C, 32'h9, 32'h480, 32'h0, 5'd0, 4'd0, 3'd3, 2'd0, 1'b0, 1'b0);
    wb_q.push_back('{rd: 5'd0, data: 32'h9, rw: 1'b0});
    send(32'h80, 32'h9, 32'h4C0, 32'h0, 5'd0, 4'd0, 3'd4, 2'd0, 1'b0, 1'b0);
    wb_q.push_back('{rd: 5'd0, data: 32'h0, rw: 1'b0});
    send(32'h84, 32'h0, 32'h500, 32'h0, 5'd0, 4'd0, 3'd6, 2'd0, 1'b0, 1'b1);
    chk("bop6_not_taken", 32'(br_taken_o), 32'd0);
    tick();

    // reset while a load waits for its response; late response ignored
    req_q.push_back('{wr: 1'b0, addr: 32'h300, be: 4'hF, wdata: 32'h0, chk_wd: 1'b0});
    send(32'h88, 32'h300, 32'h0, 32'h0, 5'd9, 4'd3, 3'd0, 2'd1, 1'b1, 1'b0);
    dm_req_ready_i = 1'b1;
    tick();
    dm_req_ready_i = 1'b0;
    chk("wait_stall", 32'(me_stall_o), 32'd1);
    chk("wait_no_req", 32'(dm_req_valid_o), 32'd0);
    RST = 1'b1;
    #1;
    chk("outputs_in_mid_reset", 32'(nz), 32'd0);
    tick();
    RST = 1'b0;
    dm_rsp_rdata_i = 32'h1111_1111;
    dm_rsp_valid_i = 1'b1;
    #1;
    chk("outputs_after_mid_reset", 32'(nz), 32'd0);
    tick();
    dm_rsp_valid_i = 1'b0;
    chk("late_rsp_no_wb", 32'(r_wb_WE), 32'd0);
    chk("late_rsp_no_req", 32'(dm_req_valid_o), 32'd0);
    tick(); tick();

    chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    chk("req_queue_drained", 32'(req_q.size()), 32'd0);
    chk("br_queue_drained", 32'(br_q.size()), 32'd0);
    chk("misaligned_pulses", 32'(mis_seen), 32'(exp_mis));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
